sirv_qspi_slave_link: RTL and testbench
=======================================

SIRV_QSPI_SLAVE_LINK -- requirements
Module: sirv_qspi_slave_link

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have ports io_port_sck, io_port_cs_0 and io_port_dq_0_i, each input, 1 bit: SPI pins from the remote master (SCK, CS, MOSI); asynchronous to clock.
REQ-004 SHALL have ports io_port_dq_1_o and io_port_dq_1_oe, each output, 1 bit: MISO data and its output enable.
REQ-005 SHALL have ports io_ctrl_sck_pol, io_ctrl_sck_pha and io_ctrl_fmt_endian, each input, 1 bit: SPI mode and bit order (endian 0 = MSB first); sampled only in IDLE.
REQ-006 SHALL have ports io_link_tx_valid (input, 1), io_link_tx_bits (input, 8) and io_link_tx_ready (output, 1): next MISO byte, valid/ready handshake.
REQ-007 SHALL have ports io_link_rx_valid (output, 1) and io_link_rx_bits (output, 8): received MOSI byte, 1-cycle pulse, no backpressure.
REQ-008 SHALL have port io_link_active, output, 1 bit: high while selected.

Function
REQ-009 SHALL pass SCK, CS and MOSI through 2-flop synchronizers plus one delay flop; edges are detected from the last two stages.
- clock SHALL be at least 4x SCK.
REQ-010 SHALL implement FSM IDLE and ACTIVE.
- IDLE->ACTIVE: on the synchronized CS falling edge; latch pol, pha and endian at this transition.
- ACTIVE->IDLE: on the synchronized CS rising edge.
REQ-011 SHALL treat an SCK edge away from pol as leading and an edge back to pol as trailing.
- pha=0: sample on leading, shift out on trailing.
- pha=1: shift out on leading, sample on trailing.
REQ-012 SHALL keep a 3-bit bit counter, cleared on entering ACTIVE and incremented per sample; it wraps 7->0.
REQ-013 SHALL assemble sampled bits in MSB-first or LSB-first order per the latched endian.
REQ-014 SHALL, on the 8th sample, register io_link_rx_valid high for exactly 1 cycle with the full byte.
- Latency: rx_valid high in the cycle after the clock edge that registers the 8th sample, i.e. 3 clock edges after the pin edge is first captured.
REQ-015 SHALL hold a 1-entry TX buffer.
- io_link_tx_ready = buffer empty.
- Capture io_link_tx_bits on valid&ready.
REQ-016 SHALL load the TX shift register at each byte start, i.e. on ACTIVE entry (pha=0) or on the first shift edge of a byte (pha=1).
- Buffer full: load the buffer and mark it empty in the same cycle.
- Buffer empty: load 8'hFF and count one underrun.
REQ-017 SHALL drive io_port_dq_1_oe = io_link_active and io_port_dq_1_o = current TX shift bit (MSB or LSB first per endian).
REQ-018 SHALL, when CS rises mid-byte, discard the partial RX byte (no rx_valid), clear the bit counter and keep the TX buffer contents.
REQ-019 SHALL give a simultaneous load-from-buffer and tx handshake in the same cycle the following result: the old byte goes to the shifter and the new byte to the buffer.
REQ-020 SHALL ignore SCK edges while in IDLE.

Reset
REQ-021 SHALL, on rst_n low, asynchronously set:
- state = IDLE, counter = 0, TX buffer empty, all synchronizers = 1.
- io_link_rx_valid = 0, io_link_rx_bits = 0, io_link_active = 0, io_port_dq_1_oe = 0, io_port_dq_1_o = 1, io_link_tx_ready = 1.
REQ-022 SHALL, on reset mid-transfer, drop the transfer and require a fresh CS falling edge before further sampling.

Configuration
REQ-023 SHALL, with macro SIRV_QSPI_SLAVE_UNDERRUN_CNT_EN defined, add output io_status_underrun_cnt [7:0].
- 8-bit saturating count of REQ-016 underruns; saturates at 8'hFF.
- Reset to 0; cleared on each IDLE->ACTIVE transition.
- Without the macro, the port and counter are absent; underrun behaviour is otherwise identical.

Verification
REQ-024 Mode 0, MSB first, MOSI 8'hA5 -> one rx_valid pulse with rx_bits = 8'hA5; MISO shifts out the preloaded 8'h3C.
REQ-025 Mode 3, LSB first, two back-to-back bytes 8'h01 and 8'h80 -> two rx_valid pulses with 8'h01 then 8'h80; bit counter wraps cleanly.
REQ-026 CS released after 5 SCK cycles -> no rx_valid; the next transfer of 8'h5A receives 8'h5A.
REQ-027 TX buffer empty at byte start -> MISO = 8'hFF; io_status_underrun_cnt = 1 (macro on).
REQ-028 rst_n asserted at bit 4 -> all outputs at reset values immediately; after release, a full transfer of 8'hC3 is received correctly.
REQ-029 tx handshake in the same cycle as a buffer load -> shifter gets the old byte and the buffer holds the new byte; io_link_tx_ready = 0.

Source files
------------

// File: rtl/sirv_qspi_slave_link_if.sv
// sirv_qspi_slave_link_if: byte-level link between the SPI slave and the host.
// The slave modport is the SPI side (sinks TX bytes, sources RX bytes);
// the master modport is the host side.
interface sirv_qspi_slave_link_if;
  logic       tx_valid;
  logic [7:0] tx_bits;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_bits;
  logic       active;

  modport master (output tx_valid, tx_bits, input tx_ready, rx_valid, rx_bits, active);
  modport slave  (input tx_valid, tx_bits, output tx_ready, rx_valid, rx_bits, active);
endinterface

// File: rtl/sirv_qspi_slave_link.sv
// sirv_qspi_slave_link: single-lane SPI slave. The pins are oversampled by
// clock: each passes through a 2-flop synchronizer plus one delay flop.
// A one-entry TX buffer feeds the MISO shifter; received MOSI bytes appear
// as one-cycle pulses on the link.
// Optional feature: define SIRV_QSPI_SLAVE_UNDERRUN_CNT_EN to add
// io_status_underrun_cnt, a saturating count of TX underruns per selection.
module sirv_qspi_slave_link (
  input  logic clock,
  input  logic rst_n,
  input  logic io_port_sck,
  input  logic io_port_cs_0,
  input  logic io_port_dq_0_i,
  output logic io_port_dq_1_o,
  output logic io_port_dq_1_oe,
  input  logic io_ctrl_sck_pol,
  input  logic io_ctrl_sck_pha,
  input  logic io_ctrl_fmt_endian,
  sirv_qspi_slave_link_if.slave link
`ifdef SIRV_QSPI_SLAVE_UNDERRUN_CNT_EN
  , output logic [7:0] io_status_underrun_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  sck_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic        pol_reg, pha_reg, endian_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  rx_shift_reg, rx_bits_reg;
  logic        rx_valid_reg;
  logic [7:0]  buf_reg, tx_shift_reg;
  logic        buf_full_reg;

  logic        sck_rise, sck_fall, cs_rise, cs_fall;
  logic        lead_edge, trail_edge, in_xfer;
  logic        sample_ev, shift_ev, byte_start, tx_hs;
  logic        enter_active, leave_active;
  logic        mosi_bit;
  logic [7:0]  rx_next;

  // Edges come from the last synchronizer stage and the delay stage.
  assign sck_rise = sck_sync_reg[1] & ~sck_sync_reg[2];
  assign sck_fall = ~sck_sync_reg[1] & sck_sync_reg[2];
  assign cs_rise  = cs_sync_reg[1] & ~cs_sync_reg[2];
  assign cs_fall  = ~cs_sync_reg[1] & cs_sync_reg[2];
  assign mosi_bit = mosi_sync_reg[2];

  // Leading edge moves SCK away from its idle polarity.
  assign lead_edge  = pol_reg ? sck_fall : sck_rise;
  assign trail_edge = pol_reg ? sck_rise : sck_fall;
  // An SCK edge coinciding with deselect is not part of the transfer.
  assign in_xfer    = (state_reg == ACTIVE) & ~cs_rise;
  assign sample_ev  = in_xfer & (pha_reg ? trail_edge : lead_edge);
  assign shift_ev   = in_xfer & (pha_reg ? lead_edge : trail_edge);
  // Byte start: selection entry in phase 0 (uses the live pha, latched on
  // this same edge), or the first shift edge of any byte.
  assign byte_start = (enter_active & ~io_ctrl_sck_pha) | (shift_ev & (bit_cnt_reg == 3'd0));
  assign tx_hs      = link.tx_valid & ~buf_full_reg;
  assign rx_next    = endian_reg ? {mosi_bit, rx_shift_reg[7:1]} : {rx_shift_reg[6:0], mosi_bit};

  // Pin synchronizers; idle-high so reset never looks like a selection.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_reg  <= 3'b111;
      cs_sync_reg   <= 3'b111;
      mosi_sync_reg <= 3'b111;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[1:0], io_port_sck};
      cs_sync_reg   <= {cs_sync_reg[1:0], io_port_cs_0};
      mosi_sync_reg <= {mosi_sync_reg[1:0], io_port_dq_0_i};
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state: selection follows the synchronized chip select.
  always_comb begin
    state_next   = state_reg;
    enter_active = 1'b0;
    leave_active = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          state_next   = ACTIVE;
          enter_active = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next   = IDLE;
          leave_active = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Mode and bit order are frozen for the whole selection.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pol_reg    <= 1'b0;
      pha_reg    <= 1'b0;
      endian_reg <= 1'b0;
    end else if (enter_active) begin
      pol_reg    <= io_ctrl_sck_pol;
      pha_reg    <= io_ctrl_sck_pha;
      endian_reg <= io_ctrl_fmt_endian;
    end
  end

  // Bit counter: restarts on every selection edge, wraps naturally 7->0.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                            bit_cnt_reg <= 3'd0;
    else if (enter_active | leave_active)  bit_cnt_reg <= 3'd0;
    else if (sample_ev)                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
  end

  // RX assembly; the byte is published with a one-cycle valid pulse.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift_reg <= 8'h00;
      rx_bits_reg  <= 8'h00;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (sample_ev) begin
        rx_shift_reg <= rx_next;
        if (bit_cnt_reg == 3'd7) begin
          rx_bits_reg  <= rx_next;
          rx_valid_reg <= 1'b1;
        end
      end
    end
  end

  // TX buffer: a handshake only happens when empty, so it never collides
  // with a drain; a drain and a fill in one cycle leaves the buffer full.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      buf_reg      <= 8'h00;
      buf_full_reg <= 1'b0;
    end else if (tx_hs) begin
      buf_reg      <= link.tx_bits;
      buf_full_reg <= 1'b1;
    end else if (byte_start) begin
      buf_full_reg <= 1'b0;
    end
  end

  // TX shifter: loads the pre-cycle buffer content (or FF on underrun),
  // then shifts toward the output end, filling with ones.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      tx_shift_reg <= 8'hFF;
    else if (byte_start)
      tx_shift_reg <= buf_full_reg ? buf_reg : 8'hFF;
    else if (shift_ev)
      tx_shift_reg <= endian_reg ? {1'b1, tx_shift_reg[7:1]} : {tx_shift_reg[6:0], 1'b1};
  end

`ifdef SIRV_QSPI_SLAVE_UNDERRUN_CNT_EN
  logic       underrun;
  logic [7:0] underrun_cnt_reg;
  assign underrun = byte_start & ~buf_full_reg;

  // Saturating underrun count, restarted on each selection.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      underrun_cnt_reg <= 8'h00;
    else if (enter_active)
      underrun_cnt_reg <= {7'd0, underrun};
    else if (underrun && underrun_cnt_reg != 8'hFF)
      underrun_cnt_reg <= underrun_cnt_reg + 8'd1;
  end

  assign io_status_underrun_cnt = underrun_cnt_reg;
`endif

  assign link.active      = (state_reg == ACTIVE);
  assign link.tx_ready    = ~buf_full_reg;
  assign link.rx_valid    = rx_valid_reg;
  assign link.rx_bits     = rx_bits_reg;
  assign io_port_dq_1_oe  = (state_reg == ACTIVE);
  assign io_port_dq_1_o   = endian_reg ? tx_shift_reg[0] : tx_shift_reg[7];

endmodule

// File: tb/tb_sirv_qspi_slave_link.sv
// tb_sirv_qspi_slave_link: directed bench acting as SPI master and link host.
// SCK half period is HALF clock cycles; pins and link inputs change on the
// falling clock edge, outputs are sampled there too.
module tb_sirv_qspi_slave_link;
  localparam int HALF = 8;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0, cs = 1'b1, dq0 = 1'b1;
  logic dq1, dq1_oe;
  logic ctl_pol = 1'b0, ctl_pha = 1'b0, ctl_endian = 1'b0;
`ifdef SIRV_QSPI_SLAVE_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif

  sirv_qspi_slave_link_if link_if();

  sirv_qspi_slave_link dut (
    .clock              (clock),
    .rst_n              (rst_n),
    .io_port_sck        (sck),
    .io_port_cs_0       (cs),
    .io_port_dq_0_i     (dq0),
    .io_port_dq_1_o     (dq1),
    .io_port_dq_1_oe    (dq1_oe),
    .io_ctrl_sck_pol    (ctl_pol),
    .io_ctrl_sck_pha    (ctl_pha),
    .io_ctrl_fmt_endian (ctl_endian),
    .link               (link_if)
`ifdef SIRV_QSPI_SLAVE_UNDERRUN_CNT_EN
    , .io_status_underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_passed = 0;
  logic [7:0] rx_q[$];

  // Collect every received byte; a pulse longer than one cycle shows up
  // as an extra queue entry.
  always @(negedge clock) begin
    if (rst_n && link_if.rx_valid === 1'b1) rx_q.push_back(link_if.rx_bits);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_tx(input logic [7:0] b);
    link_if.tx_valid = 1'b1;
    link_if.tx_bits  = b;
    wait_clk(1);
    link_if.tx_valid = 1'b0;
  endtask

  task automatic spi_begin(input logic pol, input logic pha, input logic endian);
    ctl_pol = pol; ctl_pha = pha; ctl_endian = endian;
    sck = pol;
    wait_clk(4);
    cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic spi_bit(input logic mbit, output logic sbit);
    if (!ctl_pha) begin
      dq0 = mbit;
      wait_clk(HALF);
      sbit = dq1;
      sck = ~ctl_pol;
      wait_clk(HALF);
      sck = ctl_pol;
    end else begin
      sck = ~ctl_pol;
      dq0 = mbit;
      wait_clk(HALF);
      sbit = dq1;
      sck = ctl_pol;
      wait_clk(HALF);
    end
  endtask

  task automatic spi_bits(input int nbits, input logic [15:0] mosi_w, output logic [15:0] miso_w);
    logic s;
    miso_w = 16'h0000;
    for (int b = 0; b < nbits; b++) begin
      int bi, pos;
      bi  = b / 8;
      pos = ctl_endian ? (bi * 8 + (b % 8)) : (bi * 8 + 7 - (b % 8));
      spi_bit(mosi_w[pos], s);
      miso_w[pos] = s;
    end
  endtask

  task automatic spi_xfer(input logic pol, input logic pha, input logic endian, input int nbits,
                          input logic [15:0] mosi_w, output logic [15:0] miso_w);
    spi_begin(pol, pha, endian);
    spi_bits(nbits, mosi_w, miso_w);
    spi_end();
  endtask

  task automatic test_reset();
    n_checks++; if (link_if.rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", link_if.rx_valid); else n_passed++;
    n_checks++; if (link_if.rx_bits !== 8'h00) $display("FAIL reset_rx_bits: got %h want 00", link_if.rx_bits); else n_passed++;
    n_checks++; if (link_if.active !== 1'b0) $display("FAIL reset_active: got %b want 0", link_if.active); else n_passed++;
    n_checks++; if (dq1_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", dq1_oe); else n_passed++;
    n_checks++; if (dq1 !== 1'b1) $display("FAIL reset_dq1: got %b want 1", dq1); else n_passed++;
    n_checks++; if (link_if.tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", link_if.tx_ready); else n_passed++;
    $display("test_reset: done");
  endtask

  task automatic test_mode0_msb();
    logic [15:0] miso;
    rx_q.delete();
    push_tx(8'h3C);
    n_checks++; if (link_if.tx_ready !== 1'b0) $display("FAIL m0_ready_after_push: got %b want 0", link_if.tx_ready); else n_passed++;
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 16'h00A5, miso);
    n_checks++; if (rx_q.size() != 1) $display("FAIL m0_rx_count: got %0d want 1", rx_q.size()); else n_passed++;
    n_checks++; if (rx_q.size() > 0 && rx_q[0] !== 8'hA5) $display("FAIL m0_rx_byte: got %h want a5", rx_q[0]); else n_passed++;
    n_checks++; if (miso[7:0] !== 8'h3C) $display("FAIL m0_miso: got %h want 3c", miso[7:0]); else n_passed++;
    n_checks++; if (link_if.active !== 1'b0) $display("FAIL m0_active_after: got %b want 0", link_if.active); else n_passed++;
    $display("test_mode0_msb: mosi a5 miso %h", miso[7:0]);
  endtask

  task automatic test_back_to_back();
    logic [15:0] miso;
    rx_q.delete();
    push_tx(8'h66);
    spi_xfer(1'b1, 1'b1, 1'b1, 16, 16'h8001, miso);
    n_checks++; if (rx_q.size() != 2) $display("FAIL b2b_rx_count: got %0d want 2", rx_q.size()); else n_passed++;
    n_checks++; if (rx_q.size() > 0 && rx_q[0] !== 8'h01) $display("FAIL b2b_rx0: got %h want 01", rx_q[0]); else n_passed++;
    n_checks++; if (rx_q.size() > 1 && rx_q[1] !== 8'h80) $display("FAIL b2b_rx1: got %h want 80", rx_q[1]); else n_passed++;
    n_checks++; if (miso[7:0] !== 8'h66) $display("FAIL b2b_miso0: got %h want 66", miso[7:0]); else n_passed++;
    n_checks++; if (miso[15:8] !== 8'hFF) $display("FAIL b2b_miso1_underrun: got %h want ff", miso[15:8]); else n_passed++;
    $display("test_back_to_back: miso %h", miso);
  endtask

  task automatic test_partial_abort();
    logic [15:0] miso;
    rx_q.delete();
    spi_begin(1'b0, 1'b0, 1'b0);
    fork
      spi_bits(5, 16'h00FF, miso);
      begin wait_clk(20); push_tx(8'h77); end
    join
    spi_end();
    n_checks++; if (rx_q.size() != 0) $display("FAIL abort_no_rx: got %0d pulses want 0", rx_q.size()); else n_passed++;
    n_checks++; if (link_if.tx_ready !== 1'b0) $display("FAIL abort_buffer_kept: got ready %b want 0", link_if.tx_ready); else n_passed++;
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 16'h005A, miso);
    n_checks++; if (rx_q.size() != 1) $display("FAIL abort_next_count: got %0d want 1", rx_q.size()); else n_passed++;
    n_checks++; if (rx_q.size() > 0 && rx_q[0] !== 8'h5A) $display("FAIL abort_next_rx: got %h want 5a", rx_q[0]); else n_passed++;
    n_checks++; if (miso[7:0] !== 8'h77) $display("FAIL abort_next_miso: got %h want 77", miso[7:0]); else n_passed++;
    $display("test_partial_abort: next miso %h", miso[7:0]);
  endtask

  task automatic test_underrun();
    logic [15:0] miso;
    rx_q.delete();
    spi_xfer(1'b0, 1'b1, 1'b0, 8, 16'h0096, miso);
    n_checks++; if (miso[7:0] !== 8'hFF) $display("FAIL underrun_miso: got %h want ff", miso[7:0]); else n_passed++;
    n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h96) $display("FAIL underrun_rx: got %0d bytes want one 96", rx_q.size()); else n_passed++;
`ifdef SIRV_QSPI_SLAVE_UNDERRUN_CNT_EN
    n_checks++; if (underrun_cnt !== 8'd1) $display("FAIL underrun_cnt: got %0d want 1", underrun_cnt); else n_passed++;
`endif
    $display("test_underrun: miso %h", miso[7:0]);
  endtask

  task automatic test_load_handshake();
    logic [15:0] miso;
    rx_q.delete();
    ctl_pol = 1'b0; ctl_pha = 1'b0; ctl_endian = 1'b0;
    sck = 1'b0;
    wait_clk(4);
    cs = 1'b0;
    // Entry registers on the third rising edge after the pin change.
    wait_clk(2);
    link_if.tx_valid = 1'b1;
    link_if.tx_bits  = 8'hE7;
    wait_clk(1);
    link_if.tx_valid = 1'b0;
    n_checks++; if (link_if.tx_ready !== 1'b0) $display("FAIL hs_ready: got %b want 0", link_if.tx_ready); else n_passed++;
    n_checks++; if (link_if.active !== 1'b1) $display("FAIL hs_active: got %b want 1", link_if.active); else n_passed++;
    wait_clk(HALF - 3);
    spi_bits(16, 16'h3412, miso);
    spi_end();
    n_checks++; if (miso[7:0] !== 8'hFF) $display("FAIL hs_shifter_old: got %h want ff", miso[7:0]); else n_passed++;
    n_checks++; if (miso[15:8] !== 8'hE7) $display("FAIL hs_buffer_new: got %h want e7", miso[15:8]); else n_passed++;
    n_checks++; if (rx_q.size() != 2 || rx_q[1] !== 8'h34) $display("FAIL hs_rx: got %0d bytes want 12,34", rx_q.size()); else n_passed++;
    $display("test_load_handshake: miso %h", miso);
  endtask

  task automatic test_reset_mid();
    logic [15:0] miso;
    rx_q.delete();
    spi_begin(1'b0, 1'b0, 1'b0);
    spi_bits(4, 16'h00C3, miso);
    push_tx(8'h99);
    n_checks++; if (link_if.tx_ready !== 1'b0) $display("FAIL rstmid_ready_before: got %b want 0", link_if.tx_ready); else n_passed++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (link_if.active !== 1'b0) $display("FAIL rstmid_active: got %b want 0", link_if.active); else n_passed++;
    n_checks++; if (dq1_oe !== 1'b0) $display("FAIL rstmid_oe: got %b want 0", dq1_oe); else n_passed++;
    n_checks++; if (dq1 !== 1'b1) $display("FAIL rstmid_dq1: got %b want 1", dq1); else n_passed++;
    n_checks++; if (link_if.rx_bits !== 8'h00) $display("FAIL rstmid_rx_bits: got %h want 00", link_if.rx_bits); else n_passed++;
    n_checks++; if (link_if.tx_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", link_if.tx_ready); else n_passed++;
    cs = 1'b1;
    sck = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 16'h00C3, miso);
    n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hC3) $display("FAIL rstmid_rx_after: got %0d bytes want one c3", rx_q.size()); else n_passed++;
    n_checks++; if (miso[7:0] !== 8'hFF) $display("FAIL rstmid_miso_after: got %h want ff", miso[7:0]); else n_passed++;
    $display("test_reset_mid: done");
  endtask

  initial begin
    link_if.tx_valid = 1'b0;
    link_if.tx_bits  = 8'h00;
    wait_clk(3);
    test_reset();
    rst_n = 1'b1;
    wait_clk(4);
    test_mode0_msb();
    test_back_to_back();
    test_partial_abort();
    test_underrun();
    test_load_handshake();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end
endmodule
